// File: rtl/zuart_tx_pkg.sv
// Shared UART/debug definitions: FSM encodings, default bit period and a parity helper.
// Purely declarative; no timing or flow-control behaviour of its own.
package zuart_tx_pkg;

    localparam int unsigned ZUART_CLK_DIV_DEF = 434;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_START    = 3'd1;
    localparam logic [2:0] ST_DATA     = 3'd2;
    localparam logic [2:0] ST_PARITY   = 3'd3;
    localparam logic [2:0] ST_STOP     = 3'd4;
    localparam logic [2:0] ST_DONE     = 3'd5;
    localparam logic [2:0] ST_WAIT_REL = 3'd6;

    function automatic logic parityBit(input logic [7:0] dat, input logic odd);
        return (^dat) ^ odd;
    endfunction

endpackage

// File: rtl/zuart_tx_if.sv
// Transmit request/response bundle between the configuration controller and zuart_tx.
// Level-held request, no backpressure beyond oBusy; master drives the request side.
interface zuart_tx_if;
    logic       iTxEn;
    logic [7:0] iTxData;
    logic       oTxDone;
    logic       oTxD;
    logic       oBusy;

    modport master (output iTxEn, iTxData, input oTxDone, oTxD, oBusy);
    modport slave  (input iTxEn, iTxData, output oTxDone, oTxD, oBusy);
endinterface

// File: rtl/zuart_baud_gen.sv
// Bit-period divider: counts 0..CLK_DIV-1 while enabled, ticks combinationally on the last count.
// Zero latency tick; clear has priority over enable; no backpressure.
module zuart_baud_gen
    import zuart_tx_pkg::*;
#(
    parameter int unsigned CLK_DIV = ZUART_CLK_DIV_DEF
) (
    input  logic iClk,
    input  logic iRstN,
    input  logic iClear,
    input  logic iEnable,
    output logic oTick
);

    localparam logic [15:0] LAST_CNT = 16'(CLK_DIV - 1);

    logic [15:0] divCnt;

    assign oTick = iEnable && !iClear && (divCnt == LAST_CNT);

    // Wrapping to zero on the tick keeps every bit exactly CLK_DIV cycles, so no drift accumulates.
    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            divCnt <= 16'd0;
        end else if (iClear) begin
            divCnt <= 16'd0;
        end else if (iEnable) begin
            divCnt <= oTick ? 16'd0 : divCnt + 16'd1;
        end
    end

endmodule

// File: rtl/zuart_tx.sv
// 8-bit UART transmitter, optional parity, 1/2 stop bits; oTxDone pulses one cycle after the frame.
// Line starts one cycle after acceptance; held iTxEn does not retrigger until released.
module zuart_tx
    import zuart_tx_pkg::*;
#(
    parameter int unsigned CLK_DIV    = ZUART_CLK_DIV_DEF,
    parameter bit          PARITY_EN  = 1'b0,
    parameter bit          PARITY_ODD = 1'b0,
    parameter int unsigned STOP_BITS  = 1
) (
    input  logic       iClk,
    input  logic       iRstN,
    zuart_tx_if.slave  bus
);

    logic [2:0] state;
    logic [7:0] shiftReg;
    logic [2:0] bitIdx;
    logic       stopIdx;
    logic       parReg;
    logic       txDReg;
    logic       doneReg;
    logic       baudClear;
    logic       baudEnable;
    logic       bitTick;

    assign baudClear  = (state == ST_IDLE) && bus.iTxEn;
    assign baudEnable = (state == ST_START) || (state == ST_DATA) ||
                        (state == ST_PARITY) || (state == ST_STOP);

    zuart_baud_gen #(.CLK_DIV(CLK_DIV)) baudGen (
        .iClk    (iClk),
        .iRstN   (iRstN),
        .iClear  (baudClear),
        .iEnable (baudEnable),
        .oTick   (bitTick)
    );

    assign bus.oTxD    = txDReg;
    assign bus.oTxDone = doneReg;
    assign bus.oBusy   = (state != ST_IDLE);

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            state    <= ST_IDLE;
            shiftReg <= 8'd0;
            bitIdx   <= 3'd0;
            stopIdx  <= 1'b0;
            parReg   <= 1'b0;
            txDReg   <= 1'b1;
            doneReg  <= 1'b0;
        end else begin
            doneReg <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.iTxEn) begin
                        shiftReg <= bus.iTxData;
                        // Parity is captured at acceptance so the shifting register need not keep all bits.
                        parReg   <= parityBit(bus.iTxData, PARITY_ODD);
                        bitIdx   <= 3'd0;
                        stopIdx  <= 1'b0;
                        txDReg   <= 1'b0;
                        state    <= ST_START;
                    end
                end
                ST_START: begin
                    if (bitTick) begin
                        txDReg <= shiftReg[0];
                        state  <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (bitTick) begin
                        if (bitIdx == 3'd7) begin
                            if (PARITY_EN) begin
                                txDReg <= parReg;
                                state  <= ST_PARITY;
                            end else begin
                                txDReg <= 1'b1;
                                state  <= ST_STOP;
                            end
                        end else begin
                            txDReg   <= shiftReg[1];
                            shiftReg <= {1'b0, shiftReg[7:1]};
                            bitIdx   <= bitIdx + 3'd1;
                        end
                    end
                end
                ST_PARITY: begin
                    if (bitTick) begin
                        txDReg <= 1'b1;
                        state  <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (bitTick) begin
                        if ((STOP_BITS == 1) || stopIdx) begin
                            doneReg <= 1'b1;
                            state   <= ST_DONE;
                        end else begin
                            stopIdx <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_WAIT_REL;
                end
                ST_WAIT_REL: begin
                    if (!bus.iTxEn) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    txDReg <= 1'b1;
                    state  <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/zuart_tx.md
ZUART_TX -- requirements
Module: zuart_tx

Interface
REQ-001 SHALL provide parameter CLK_DIV, default 434, clock cycles per UART bit; legal range 2..65535.
REQ-002 SHALL provide parameter PARITY_EN, default 0, 1 inserts a parity bit after data bit 7.
REQ-003 SHALL provide parameter PARITY_ODD, default 0, 0 = even parity, 1 = odd parity; ignored when PARITY_EN=0.
REQ-004 SHALL provide parameter STOP_BITS, default 1, number of stop bits; legal values 1 or 2.
REQ-005 SHALL provide port iClk, input, 1, the single clock; all logic on its rising edge.
REQ-006 SHALL provide port iRstN, input, 1, asynchronous active-low reset.
REQ-007 SHALL provide port iTxEn, input, 1, level-held transmit request from the configuration controller.
REQ-008 SHALL provide port iTxData, input, 8, byte to send; valid while iTxEn=1.
REQ-009 SHALL provide port oTxDone, output, 1, one-cycle pulse at end of frame.
REQ-010 SHALL provide port oTxD, output, 1, serial line; idle high.
REQ-011 SHALL provide port oBusy, output, 1, high from acceptance until re-armed.

Function
REQ-012 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP, DONE, WAIT_REL.
REQ-013 IDLE: when iTxEn=1, SHALL latch iTxData into a shift register, clear bit counter and divider, go to START (acceptance cycle T0).
REQ-014 SHALL drive oTxD low from T0+1 for exactly CLK_DIV cycles (START).
REQ-015 DATA: SHALL send 8 bits LSB first, each held exactly CLK_DIV cycles; 3-bit index, exit after index 7.
REQ-016 PARITY (only if PARITY_EN=1): SHALL send XOR of the 8 latched bits, inverted when PARITY_ODD=1, for CLK_DIV cycles; otherwise DATA goes directly to STOP.
REQ-017 STOP: SHALL drive oTxD high for STOP_BITS*CLK_DIV cycles.
REQ-018 Frame length SHALL be F = CLK_DIV*(10+PARITY_EN+STOP_BITS-1) cycles; oTxDone SHALL be high exactly at cycle T0+F+1 (DONE), one cycle only.
REQ-019 After DONE SHALL enter WAIT_REL and return to IDLE only on the first cycle iTxEn=0; no second frame while iTxEn stays high.
REQ-020 iTxData changes after T0 SHALL NOT affect the frame in flight.
REQ-021 iTxEn deasserted mid-frame SHALL NOT abort the frame; oTxDone still pulses; WAIT_REL then exits immediately.
REQ-022 Divider SHALL count 0..CLK_DIV-1 and wrap to 0 at each bit boundary; no cumulative drift across a frame.
REQ-023 oTxD SHALL be driven from a register (glitch-free); high in IDLE, DONE, WAIT_REL.
REQ-024 oBusy SHALL be low only in IDLE.

Reset
REQ-025 On iRstN=0, SHALL asynchronously force state IDLE, oTxD=1, oTxDone=0, oBusy=0, divider, bit index and shift register 0.
REQ-026 Reset mid-frame SHALL return oTxD high immediately; after release, a held iTxEn=1 SHALL start a fresh frame.

Structure
REQ-027 State encodings and CLK_DIV default SHALL live in the shared define include used by the UART/debug blocks.
REQ-028 The bit-period divider SHALL be one sub-module, zuart_baud_gen (inputs clear/enable, output bit-end tick).

Verification
REQ-029 CLK_DIV=4, no parity, 1 stop; iTxEn=1, iTxData=0x56 -> oTxD 0 (T0+1..4), then 0,1,1,0,1,0,1,0, then 1; oTxDone only at T0+41.
REQ-030 Handshake: byte 0x56, drop iTxEn the cycle after oTxDone, reassert with 0x40 -> two back-to-back frames, exactly two oTxDone pulses.
REQ-031 iTxEn held high 200 cycles, CLK_DIV=4, byte 0xA5 -> exactly one frame, one oTxDone, oBusy high until iTxEn falls.
REQ-032 PARITY_EN=1, byte 0x56 -> parity bit 0 (PARITY_ODD=0) / 1 (PARITY_ODD=1) at bit slot 9; oTxDone at T0+45.
REQ-033 STOP_BITS=2, CLK_DIV=4 -> line high 8 cycles after bit 7; oTxDone at T0+45.
REQ-034 iRstN pulsed low during DATA -> oTxD=1, oBusy=0 in same cycle; no oTxDone; frame restarts cleanly after release.
